// File: rtl/pc_gen.sv
// Fetch PC generator: reset vector, trap/jump/hold redirects, sequential fetch.
// Define PC_MISALIGN_EN to halt on misaligned jump targets instead of masking them.
module pc_gen #(
  parameter int unsigned              ADDR_W      = 32,
  parameter logic [ADDR_W-1:0]        RESET_VEC   = '0,
  parameter int unsigned              FETCH_BYTES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trap_flag_i,
  input  logic [ADDR_W-1:0] trap_addr_i,
  input  logic              jump_flag_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  input  logic              hold_flag_i,
  input  logic [ADDR_W-1:0] hold_addr_i,
  input  logic              gnt_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic              req_o,
  output logic [31:0]       fetch_cnt_o
);

`ifdef PC_MISALIGN_EN
  typedef enum logic [1:0] {IDLE, RUN, HOLD, HALT} state_t;
`else
  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
`endif

  localparam logic [ADDR_W-1:0] ALIGN = ~ADDR_W'(3);
  localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(FETCH_BYTES);

  state_t            state;
  logic [ADDR_W-1:0] trap_tgt;
  logic [ADDR_W-1:0] jump_tgt;

  assign trap_tgt = trap_addr_i & ALIGN;

`ifdef PC_MISALIGN_EN
  logic jump_bad;
  assign jump_tgt = jump_addr_i;
  assign jump_bad = |jump_addr_i[1:0];
`else
  assign jump_tgt = jump_addr_i & ALIGN;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pc_o        <= RESET_VEC;
      req_o       <= 1'b0;
      fetch_cnt_o <= '0;
    end else begin
      // grants count even when the same cycle redirects
      if (req_o && gnt_i)
        fetch_cnt_o <= fetch_cnt_o + 32'd1;
      if (state == IDLE) begin
        state <= RUN;
        req_o <= 1'b1;
        pc_o  <= RESET_VEC;
      end else if (trap_flag_i) begin
        state <= RUN;
        req_o <= 1'b1;
        pc_o  <= trap_tgt;
`ifdef PC_MISALIGN_EN
      end else if (state == HALT) begin
        state <= HALT;
      end else if (jump_flag_i && jump_bad) begin
        state <= HALT;
        req_o <= 1'b0;
        pc_o  <= jump_tgt;
`endif
      end else if (jump_flag_i) begin
        state <= RUN;
        req_o <= 1'b1;
        pc_o  <= jump_tgt;
      end else if (hold_flag_i) begin
        state <= HOLD;
        req_o <= 1'b0;
        pc_o  <= hold_addr_i;
      end else if (state == HOLD) begin
        state <= RUN;
        req_o <= 1'b1;
      end else if (gnt_i) begin
        pc_o  <= pc_o + STEP;
      end
    end
  end

endmodule
